// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-pattern detector.
//
// Looks for a run-time selected pattern of 1..MAX_LEN bits in a qualified
// serial stream. Matching may be overlapping or non-overlapping. Comes out of
// reset as an overlapping 1011 detector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   inp_bit      serial data bit, accepted only when in_valid=1
//   in_valid     input qualifier
//   cfg_load     latch pattern/pat_len/overlap_en, clear history and count
//   pattern      pattern[pat_len-1] is the first bit received, pattern[0] last
//   pat_len      pattern length, legal range 1..MAX_LEN
//   overlap_en   1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      synchronous clear of match_count (wins over a match)
//   seq_seen     registered one-cycle match pulse
//   match_count  saturating match counter
//   cfg_err      latched pat_len is illegal; detection disabled
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inp_bit,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap_en,
   input  logic               cnt_clr,
   output logic               seq_seen,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   localparam logic [MAX_LEN-1:0] RST_PAT  = MAX_LEN'(4'b1011);
   localparam logic [LEN_W-1:0]   RST_LEN  = LEN_W'(4);
   localparam logic [LEN_W-1:0]   MAX_FILL = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   logic [MAX_LEN-1:0] pat_q,  pat_d;
   logic [LEN_W-1:0]   len_q,  len_d;
   logic               ovl_q,  ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               seen_q, seen_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;
   logic               err_q,  err_d;

   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] hist_n;
   logic [LEN_W-1:0]   fill_n;
   logic               match;

   // Selects the low len_q bits; bits of the pattern above the length are
   // don't-care.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
   end

   // Candidate history and fill as if the current bit is accepted.
   assign hist_n = {hist_q[MAX_LEN-2:0], inp_bit};
   assign fill_n = (fill_q == MAX_FILL) ? fill_q : fill_q + LEN_W'(1);

   // fill_n >= len_q guarantees every compared bit was actually received
   // since the last reset, reload or non-overlapping match.
   assign match = !err_q && (fill_n >= len_q) &&
                  (((hist_n ^ pat_q) & len_mask) == '0);

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      seen_d = 1'b0;

      if (cfg_load) begin
         // The bit presented alongside a reload is dropped.
         pat_d  = pattern;
         len_d  = pat_len;
         ovl_d  = overlap_en;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
         err_d  = (pat_len == '0) || (pat_len > MAX_FILL);
      end else begin
         if (in_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (match) begin
               seen_d = 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               // Non-overlapping: the next match needs len_q fresh bits.
               if (!ovl_q) begin
                  fill_d = '0;
               end
            end
         end
         if (cnt_clr) begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= RST_PAT;
         len_q  <= RST_LEN;
         ovl_q  <= 1'b1;
         hist_q <= '0;
         fill_q <= '0;
         seen_q <= 1'b0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before the edge, independent of statement order.
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         seen_q <= seen_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign seq_seen    = seen_q;
   assign match_count = cnt_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog. Two instances share the inputs: the default
// build (CNT_W=8) and a CNT_W=2 build for short saturation checks. Expected
// values come from a queue-based model of the received bit stream.
module tb_seq_detect_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;

   logic               clk;
   logic               reset;
   logic               inp_bit;
   logic               in_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap_en;
   logic               cnt_clr;
   logic               seq_seen,  seq_seen2;
   logic [7:0]         match_count;
   logic [1:0]         match_count2;
   logic               cfg_err,   cfg_err2;

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
      .overlap_en(overlap_en), .cnt_clr(cnt_clr), .seq_seen(seq_seen),
      .match_count(match_count), .cfg_err(cfg_err)
   );

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
      .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
      .overlap_en(overlap_en), .cnt_clr(cnt_clr), .seq_seen(seq_seen2),
      .match_count(match_count2), .cfg_err(cfg_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: configuration plus the list of bits received since the
   // last reset, reload or non-overlapping match.
   int         m_pat, m_len;
   bit         m_ovl;
   int         mq[$];
   logic       exp_seen, exp_err;
   logic [7:0] exp_cnt;
   logic [1:0] exp_cnt2;

   task automatic model_reset();
      m_pat = 'b1011; m_len = 4; m_ovl = 1'b1;
      mq.delete();
      exp_seen = 1'b0; exp_err = 1'b0; exp_cnt = '0; exp_cnt2 = '0;
   endtask

   // True when the last m_len received bits, oldest first, spell the pattern
   // read from bit m_len-1 down to bit 0.
   function automatic bit tail_match();
      int v;
      if (mq.size() < m_len) return 1'b0;
      v = 0;
      for (int i = 0; i < m_len; i++) v = v * 2 + mq[mq.size() - m_len + i];
      return v == (m_pat % (1 << m_len));
   endfunction

   // One clock: apply inputs at the falling edge, advance the model, and
   // return 1 time unit after the rising edge for sampling.
   task automatic drive(input bit vin, input bit b, input bit load, input bit clr);
      @(negedge clk);
      in_valid = vin; inp_bit = b; cfg_load = load; cnt_clr = clr;
      exp_seen = 1'b0;
      if (load) begin
         m_pat = int'(pattern); m_len = int'(pat_len); m_ovl = overlap_en;
         exp_err = (pat_len == 0) || (pat_len > MAX_LEN);
         mq.delete();
         exp_cnt = '0; exp_cnt2 = '0;
      end else begin
         if (vin) begin
            mq.push_back(int'(b));
            if (mq.size() > 2 * MAX_LEN) void'(mq.pop_front());
            if (!exp_err && tail_match()) begin
               exp_seen = 1'b1;
               if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
               if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
               if (!m_ovl) mq.delete();
            end
         end
         if (clr) begin
            exp_cnt = '0; exp_cnt2 = '0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [7:0] p, input int len, input bit ovl);
      pattern = p; pat_len = LEN_W'(len); overlap_en = ovl;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 0; inp_bit = 0; cfg_load = 0; cnt_clr = 0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; inp_bit = 0; cfg_load = 0; cnt_clr = 0;
      pattern = '0; pat_len = '0; overlap_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({seq_seen, match_count, cfg_err} !== 10'b0)
         $display("FAIL reset_state: seen=%0b cnt=%0d err=%0b want 0/0/0", seq_seen, match_count, cfg_err);
      else n_pass++;
      n_checks++;
      if ({seq_seen2, match_count2, cfg_err2} !== 4'b0)
         $display("FAIL reset_state2: seen=%0b cnt=%0d err=%0b want 0/0/0", seq_seen2, match_count2, cfg_err2);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_default();
      logic [6:0] bits = 7'b1011011;
      logic [6:0] seen_mask = '0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, bits[6-i], 1'b0, 1'b0);
         seen_mask[i] = seq_seen;
         n_checks++;
         if (seq_seen !== exp_seen || match_count !== exp_cnt)
            $display("FAIL default bit%0d: seen=%0b cnt=%0d want %0b/%0d", i + 1, seq_seen, match_count, exp_seen, exp_cnt);
         else n_pass++;
      end
      n_checks++;
      if (seen_mask !== 7'h48 || match_count !== 8'd2)
         $display("FAIL default_summary: pulses=%b cnt=%0d want 1001000/2", seen_mask, match_count);
      else n_pass++;
   endtask

   task automatic test_overlap();
      logic [3:0] seen_mask;
      for (int pass = 0; pass < 2; pass++) begin
         load_cfg(8'b11, 2, pass == 0);
         seen_mask = '0;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            seen_mask[i] = seq_seen;
            n_checks++;
            if (seq_seen !== exp_seen || match_count !== exp_cnt)
               $display("FAIL overlap%0d bit%0d: seen=%0b cnt=%0d want %0b/%0d", pass, i + 1, seq_seen, match_count, exp_seen, exp_cnt);
            else n_pass++;
         end
         n_checks++;
         if (pass == 0 && (seen_mask !== 4'hE || match_count !== 8'd3))
            $display("FAIL overlap_on_summary: pulses=%b cnt=%0d want 1110/3", seen_mask, match_count);
         else if (pass == 1 && (seen_mask !== 4'hA || match_count !== 8'd2))
            $display("FAIL overlap_off_summary: pulses=%b cnt=%0d want 1010/2", seen_mask, match_count);
         else n_pass++;
      end
   endtask

   task automatic test_gap();
      bit vin_s[7] = '{1, 1, 0, 0, 0, 1, 1};
      bit bit_s[7] = '{1, 0, 0, 0, 0, 1, 1};
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(vin_s[i], bit_s[i], 1'b0, 1'b0);
         pulses += int'(seq_seen);
         n_checks++;
         if (seq_seen !== exp_seen || match_count !== exp_cnt)
            $display("FAIL gap cyc%0d: seen=%0b cnt=%0d want %0b/%0d", i, seq_seen, match_count, exp_seen, exp_cnt);
         else n_pass++;
      end
      n_checks++;
      if (pulses != 1 || seq_seen !== 1'b1)
         $display("FAIL gap_summary: pulses=%0d last=%0b want 1/1", pulses, seq_seen);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit seq_b[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
      load_cfg(8'h01, 1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (seq_seen !== 1'b1 || match_count !== 8'd1)
         $display("FAIL pre_async: seen=%0b cnt=%0d want 1/1", seq_seen, match_count);
      else n_pass++;
      // Assert reset between edges and look before any further clock edge.
      #1 reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (seq_seen !== 1'b0 || match_count !== 8'd0 || match_count2 !== 2'd0)
         $display("FAIL async_reset: seen=%0b cnt=%0d cnt2=%0d want 0/0/0", seq_seen, match_count, match_count2);
      else n_pass++;
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1, seq_b[i], 1'b0, 1'b0);
      #1 reset = 1'b1;
      model_reset();
      #1 reset = 1'b0;
      for (int i = 3; i < 8; i++) begin
         drive(1'b1, seq_b[i], 1'b0, 1'b0);
         n_checks++;
         if (seq_seen !== exp_seen || match_count !== exp_cnt)
            $display("FAIL reset_mid bit%0d: seen=%0b cnt=%0d want %0b/%0d", i - 2, seq_seen, match_count, exp_seen, exp_cnt);
         else n_pass++;
         if (i == 3) begin
            n_checks++;
            if (seq_seen !== 1'b0 || match_count !== 8'd0)
               $display("FAIL reset_mid_lost: seen=%0b cnt=%0d want 0/0", seq_seen, match_count);
            else n_pass++;
         end
      end
   endtask

   task automatic test_long_and_err();
      logic [7:0] p = 8'hA5;
      logic [7:0] seen_mask = '0;
      logic [3:0] b1011 = 4'b1011;
      load_cfg(p, 8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, p[7-i], 1'b0, 1'b0);
         seen_mask[i] = seq_seen;
      end
      n_checks++;
      if (seen_mask !== 8'h80 || match_count !== 8'd1)
         $display("FAIL long_pattern: pulses=%b cnt=%0d want 10000000/1", seen_mask, match_count);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         load_cfg(8'h0B, (k == 0) ? 0 : 9, 1'b1);
         n_checks++;
         if (cfg_err !== 1'b1 || cfg_err2 !== 1'b1)
            $display("FAIL cfg_err_set len%0d: err=%0b want 1", pat_len, cfg_err);
         else n_pass++;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, b1011[3-i], 1'b0, 1'b0);
            n_checks++;
            if (seq_seen !== 1'b0 || match_count !== exp_cnt || exp_seen !== 1'b0)
               $display("FAIL cfg_err_quiet bit%0d: seen=%0b cnt=%0d want 0/%0d", i + 1, seq_seen, match_count, exp_cnt);
            else n_pass++;
         end
      end
      load_cfg(8'h0B, 4, 1'b1);
      n_checks++;
      if (cfg_err !== 1'b0)
         $display("FAIL cfg_err_clear: err=%0b want 0", cfg_err);
      else n_pass++;
   endtask

   task automatic test_cfg_drop();
      load_cfg(8'h01, 1, 1'b1);
      // Reload with a valid '1' presented: the bit must not match.
      pattern = 8'h01; pat_len = 4'd1; overlap_en = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (seq_seen !== 1'b0)
         $display("FAIL cfg_drop: seen=%0b want 0", seq_seen);
      else n_pass++;
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (seq_seen !== 1'b1 || match_count !== 8'd1)
         $display("FAIL cfg_drop_next: seen=%0b cnt=%0d want 1/1", seq_seen, match_count);
      else n_pass++;
   endtask

   task automatic test_saturate();
      logic [1:0] want2[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      load_cfg(8'h01, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (match_count2 !== want2[i] || match_count2 !== exp_cnt2 || seq_seen2 !== 1'b1)
            $display("FAIL sat2 bit%0d: cnt2=%0d seen2=%0b want %0d/1", i + 1, match_count2, seq_seen2, want2[i]);
         else n_pass++;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (match_count2 !== 2'd0 || match_count !== 8'd0 || seq_seen !== 1'b1)
         $display("FAIL clr_wins: cnt=%0d cnt2=%0d seen=%0b want 0/0/1", match_count, match_count2, seq_seen);
      else n_pass++;
      repeat (260) drive(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (match_count !== 8'hFF || exp_cnt !== 8'hFF)
         $display("FAIL sat8: cnt=%0d want 255", match_count);
      else n_pass++;
   endtask

   task automatic test_random();
      int len, r;
      bit vin, b, ld, clr;
      for (int c = 0; c < 8; c++) begin
         r = int'($urandom_range(0, 7));
         if (r == 0) len = $urandom_range(0, 1) ? 0 : int'($urandom_range(9, 15));
         else if (r <= 5) len = int'($urandom_range(1, 4));
         else len = int'($urandom_range(5, 8));
         load_cfg(8'($urandom), len, 1'($urandom));
         for (int i = 0; i < 80; i++) begin
            vin = ($urandom_range(0, 4) != 0);
            b   = 1'($urandom);
            clr = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 49) == 0);
            if (ld) begin
               pattern = 8'($urandom); pat_len = 4'($urandom_range(1, 4));
               overlap_en = 1'($urandom);
            end
            drive(vin, b, ld, clr);
            n_checks++;
            if (seq_seen !== exp_seen || match_count !== exp_cnt || cfg_err !== exp_err ||
                seq_seen2 !== exp_seen || match_count2 !== exp_cnt2)
               $display("FAIL random cfg%0d cyc%0d: seen=%0b cnt=%0d err=%0b cnt2=%0d want %0b/%0d/%0b/%0d",
                        c, i, seq_seen, match_count, cfg_err, match_count2, exp_seen, exp_cnt, exp_err, exp_cnt2);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_overlap();
      test_gap();
      test_reset_mid();
      test_long_and_err();
      test_cfg_drop();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
